// File: rtl/easy_fifo_axis_pkt_sync.sv
// Single-clock AXI-Stream FIFO with tkeep/tlast/tuser sideband, optional store-and-forward
// packet mode, optional output register and fill flags. Build macro EASY_FIFO_PKT_DROP_EN enables drop-on-full packet mode.
module easy_fifo_axis_pkt_sync #(
  parameter int DWIDTH        = 32,
  parameter int UWIDTH        = 1,
  parameter int DEPTH         = 16,
  parameter int PKT_MODE      = 1,
  parameter int OUTPUT_REG    = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DWIDTH-1:0]         s_axis_tdata,
  input  logic [DWIDTH/8-1:0]       s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [UWIDTH-1:0]         s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DWIDTH-1:0]         m_axis_tdata,
  output logic [DWIDTH/8-1:0]       m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [UWIDTH-1:0]         m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic [$clog2(DEPTH):0]    pkt_cnt,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      drop_pulse
);

  localparam int KWIDTH = DWIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int EW     = UWIDTH + 1 + KWIDTH + DWIDTH;
  localparam int LAST_B = DWIDTH + KWIDTH;

`ifdef EASY_FIFO_PKT_DROP_EN
  localparam bit DROP = (PKT_MODE != 0);
`else
  localparam bit DROP = 1'b0;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, cmt_ptr, vis_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, cmt_ptr_nxt, cnt_nxt, pkt_cnt_nxt;
  logic          ready_en, dropping;
  logic          full, fifo_avail, mem_rd, mem_wr, wr_acc, rollback, drop_now;
  logic          out_valid;
  logic [EW-1:0] rd_data, out_data, s_entry;

  assign s_entry = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // In drop mode the reader must never see a packet that might still be rolled back.
  assign vis_ptr = DROP ? cmt_ptr : wr_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    fifo_avail = (vis_ptr != rd_ptr);
    if (!DROP && PKT_MODE != 0)
      fifo_avail = (vis_ptr != rd_ptr) && ((pkt_cnt != '0) || full);
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic load;
    assign load   = m_axis_tready | ~out_valid;
    assign mem_rd = fifo_avail & load;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (load) begin
        out_valid <= fifo_avail;
        out_data  <= fifo_avail ? rd_data : '0;
      end
    end
  end else begin : g_fwft
    assign mem_rd    = fifo_avail & m_axis_tready;
    assign out_valid = fifo_avail;
    assign out_data  = fifo_avail ? rd_data : '0;
  end

  assign m_axis_tvalid = out_valid;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_data;

  // A read freeing the full slot in the same cycle lets a write through, so a
  // full FIFO with a draining consumer keeps streaming.
  assign s_axis_tready = ready_en & (DROP | ~full | mem_rd);
  assign wr_acc        = s_axis_tvalid & s_axis_tready;
  assign drop_now      = DROP & wr_acc & (dropping | full);
  assign rollback      = DROP & wr_acc & ~dropping & full;
  assign mem_wr        = wr_acc & ~drop_now;
  assign drop_pulse    = drop_now & s_axis_tlast;

  assign wr_ptr_nxt  = rollback ? cmt_ptr : wr_ptr + PW'(mem_wr);
  assign cmt_ptr_nxt = (mem_wr && s_axis_tlast) ? wr_ptr + PW'(1) : cmt_ptr;
  assign rd_ptr_nxt  = rd_ptr + PW'(mem_rd);
  assign cnt_nxt     = wr_ptr_nxt - rd_ptr_nxt;
  assign pkt_cnt_nxt = pkt_cnt + PW'(mem_wr & s_axis_tlast) - PW'(mem_rd & rd_data[LAST_B]);

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr[AW-1:0]] <= s_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cmt_ptr      <= '0;
      ready_en     <= 1'b0;
      dropping     <= 1'b0;
      fifo_cnt     <= '0;
      pkt_cnt      <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      cmt_ptr      <= cmt_ptr_nxt;
      ready_en     <= 1'b1;
      if (drop_now) dropping <= ~s_axis_tlast;
      fifo_cnt     <= cnt_nxt;
      pkt_cnt      <= pkt_cnt_nxt;
      almost_full  <= (cnt_nxt >= PW'(AFULL_THRESH));
      almost_empty <= (cnt_nxt <= PW'(AEMPTY_THRESH));
    end
  end

endmodule

// File: tb/tb_easy_fifo_axis_pkt_sync.sv
// Bench for easy_fifo_axis_pkt_sync: three configurations (cut-through, packet mode,
// registered output) each checked every cycle against a queue-based model.
module tb_easy_fifo_axis_pkt_sync;

`ifdef EASY_FIFO_PKT_DROP_EN
  localparam bit DROP_DEF = 1'b1;
`else
  localparam bit DROP_DEF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_tdata [3], m_tdata [3];
  logic [3:0]  s_tkeep [3], m_tkeep [3];
  logic        s_tlast [3], m_tlast [3];
  logic [0:0]  s_tuser [3], m_tuser [3];
  logic        s_tvalid [3], s_tready [3], m_tvalid [3], m_tready [3];
  logic [4:0]  fifo_cnt [3], pkt_cnt [3];
  logic        afull [3], aempty [3], drop_pulse [3];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h @%0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int PM   = (g == 1) ? 1 : 0;
    localparam int OREG = (g == 2) ? 1 : 0;
    localparam bit DROP = (PM != 0) && DROP_DEF;

    easy_fifo_axis_pkt_sync #(
      .DWIDTH(32), .UWIDTH(1), .DEPTH(16), .PKT_MODE(PM), .OUTPUT_REG(OREG)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata[g]), .s_axis_tkeep(s_tkeep[g]), .s_axis_tlast(s_tlast[g]),
      .s_axis_tuser(s_tuser[g]), .s_axis_tvalid(s_tvalid[g]), .s_axis_tready(s_tready[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]), .m_axis_tlast(m_tlast[g]),
      .m_axis_tuser(m_tuser[g]), .m_axis_tvalid(m_tvalid[g]), .m_axis_tready(m_tready[g]),
      .fifo_cnt(fifo_cnt[g]), .pkt_cnt(pkt_cnt[g]), .almost_full(afull[g]),
      .almost_empty(aempty[g]), .drop_pulse(drop_pulse[g])
    );

    // Model: q holds deliverable (committed) beats, p the packet still being written
    // in drop mode, ob/ov the output register slot.
    logic [37:0] q[$];
    logic [37:0] p[$];
    logic [37:0] ob = '0, ent, e_data;
    bit drp = 0, rdy = 0, ov = 0;
    int e_cnt, e_pk;
    bit e_full, e_avail, e_valid, e_mrd, e_sready, e_drop;

    task automatic calc();
      e_cnt = q.size() + p.size();
      e_pk = 0;
      foreach (q[i]) if (q[i][36]) e_pk++;
      e_full = (e_cnt == 16);
      if (DROP || PM == 0) e_avail = (q.size() > 0);
      else e_avail = (q.size() > 0) && (e_pk > 0 || e_full);
      e_valid  = (OREG != 0) ? ov : e_avail;
      e_data   = (OREG != 0) ? ob : (e_avail ? q[0] : '0);
      e_mrd    = e_avail && ((OREG != 0) ? (m_tready[g] || !ov) : m_tready[g]);
      e_sready = rdy && (DROP || !e_full || e_mrd);
      e_drop   = DROP && rdy && s_tvalid[g] && s_tlast[g] && (drp || e_full);
    endtask

    initial forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); p.delete(); drp = 0; rdy = 0; ov = 0; ob = '0;
      end else begin
        calc();
        ent = {s_tuser[g], s_tlast[g], s_tkeep[g], s_tdata[g]};
        if (OREG != 0) begin
          if (m_tready[g] || !ov) begin
            if (e_avail) begin ob = q.pop_front(); ov = 1; end
            else begin ob = '0; ov = 0; end
          end
        end else if (e_valid && m_tready[g]) begin
          void'(q.pop_front());
        end
        if (s_tvalid[g] && e_sready) begin
          if (!DROP) q.push_back(ent);
          else if (drp) drp = !s_tlast[g];
          else if (e_full) begin p.delete(); drp = !s_tlast[g]; end
          else begin
            p.push_back(ent);
            if (s_tlast[g]) begin
              foreach (p[i]) q.push_back(p[i]);
              p.delete();
            end
          end
        end
        rdy = 1;
      end
    end

    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); p.delete(); drp = 0; rdy = 0; ov = 0; ob = '0;
        chk("rst_valid", g, 64'(m_tvalid[g]), 64'd0);
        chk("rst_sready", g, 64'(s_tready[g]), 64'd0);
        chk("rst_cnt", g, 64'(fifo_cnt[g]), 64'd0);
        chk("rst_pkt", g, 64'(pkt_cnt[g]), 64'd0);
        chk("rst_flags", g, 64'({afull[g], aempty[g], drop_pulse[g]}), 64'b010);
        chk("rst_data", g, 64'({m_tuser[g], m_tlast[g], m_tkeep[g], m_tdata[g]}), 64'd0);
      end else begin
        calc();
        chk("valid", g, 64'(m_tvalid[g]), 64'(e_valid));
        chk("sready", g, 64'(s_tready[g]), 64'(e_sready));
        chk("fifo_cnt", g, 64'(fifo_cnt[g]), 64'(e_cnt));
        chk("pkt_cnt", g, 64'(pkt_cnt[g]), 64'(e_pk));
        chk("almost_full", g, 64'(afull[g]), 64'(e_cnt >= 14));
        chk("almost_empty", g, 64'(aempty[g]), 64'(e_cnt <= 2));
        chk("drop_pulse", g, 64'(drop_pulse[g]), 64'(e_drop));
        chk("data", g, 64'({m_tuser[g], m_tlast[g], m_tkeep[g], m_tdata[g]}), 64'(e_data));
      end
    end
  end

  int outb [3], ndrop [3], peak [3], rem [3], pv [3], pr [3];
  bit acc [3];

  function automatic logic [37:0] mk(input logic [31:0] d, input logic [3:0] k,
                                     input logic l, input logic u);
    return {u, l, k, d};
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      acc[i] = s_tvalid[i] & s_tready[i];
      if (m_tvalid[i] & m_tready[i]) outb[i]++;
      if (drop_pulse[i]) ndrop[i]++;
      if (int'(pkt_cnt[i]) > peak[i]) peak[i] = int'(pkt_cnt[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic [37:0] e);
    {s_tuser[g], s_tlast[g], s_tkeep[g], s_tdata[g]} = e;
    s_tvalid[g] = 1'b1;
  endtask

  task automatic send(input int g, input logic [37:0] e, output int cyc);
    cyc = 0;
    drive(g, e);
    do begin step(); cyc++; end while (!acc[g] && cyc < 64);
    s_tvalid[g] = 1'b0;
    chk("send_accept", g, 64'(acc[g]), 64'd1);
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b, b2, d, tot, n;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 0; s_tuser[i] = '0;
      s_tvalid[i] = 0; m_tready[i] = 0; rem[i] = 0; pv[i] = 70; pr[i] = 70;
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rdy_after_rel", 0, 64'(s_tready[0]), 64'd1);

    // reset in the middle of a packet, then a clean 3-beat packet
    send(0, mk(32'h1111_0001, 4'hF, 0, 0), c);
    send(0, mk(32'h1111_0002, 4'hF, 0, 0), c);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cnt", 0, 64'(fifo_cnt[0]), 64'd0);
    chk("midrst_sready", 0, 64'(s_tready[0]), 64'd0);
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    step();
    m_tready[0] = 1; b = outb[0];
    for (int k = 1; k <= 3; k++) send(0, mk(32'h1212_0000 + k, 4'hF, k == 3, 0), c);
    repeat (4) step();
    chk("rst_pkt_out", 0, 64'(outb[0] - b), 64'd3);

    // cut-through instance filled with single beats, then read+write at full
    m_tready[0] = 0;
    for (int k = 0; k < 16; k++) send(0, mk(32'h2000_0000 + k, 4'(k), 1, 1'(k)), c);
    chk("full_sready", 0, 64'(s_tready[0]), 64'd0);
    chk("full_cnt", 0, 64'(fifo_cnt[0]), 64'd16);
    chk("full_af", 0, 64'(afull[0]), 64'd1);
    chk("full_head", 0, 64'(m_tdata[0]), 64'h2000_0000);
    b = outb[0];
    drive(0, mk(32'h2000_00FF, 4'h1, 1, 0));
    m_tready[0] = 1;
    step();
    s_tvalid[0] = 0;
    chk("full_rdwr_acc", 0, 64'(acc[0]), 64'd1);
    chk("full_rdwr_cnt", 0, 64'(fifo_cnt[0]), 64'd16);
    repeat (20) step();
    chk("full_drain", 0, 64'(outb[0] - b), 64'd17);
    chk("drain_cnt", 0, 64'(fifo_cnt[0]), 64'd0);

    // store-and-forward: nothing visible until tlast is stored
    m_tready[1] = 1; b = outb[1];
    for (int k = 1; k <= 4; k++) begin
      send(1, mk(32'h3000_0000 + k, 4'(k), k == 4, 0), c);
      chk("pkt_hold", 1, 64'(m_tvalid[1]), 64'(k == 4));
    end
    chk("pkt_cnt1", 1, 64'(pkt_cnt[1]), 64'd1);
    chk("pkt_first", 1, 64'(m_tdata[1]), 64'h3000_0001);
    repeat (6) step();
    chk("pkt_out", 1, 64'(outb[1] - b), 64'd4);

`ifdef EASY_FIFO_PKT_DROP_EN
    // A (3) fits, B (20) cannot and is dropped, C (2) fits behind A
    m_tready[1] = 0; b = outb[1]; d = ndrop[1]; peak[1] = 0;
    for (int k = 0; k < 3; k++) send(1, mk(32'h5A00_0000 + k, 4'hF, k == 2, 0), c);
    for (int k = 0; k < 20; k++) send(1, mk(32'h5B00_0000 + k, 4'h3, k == 19, 1), c);
    for (int k = 0; k < 2; k++) send(1, mk(32'h5C00_0000 + k, 4'h7, k == 1, 0), c);
    chk("drp_sready", 1, 64'(s_tready[1]), 64'd1);
    chk("drp_pkt2", 1, 64'(pkt_cnt[1]), 64'd2);
    chk("drp_cnt", 1, 64'(fifo_cnt[1]), 64'd5);
    m_tready[1] = 1;
    repeat (10) step();
    chk("drp_pulses", 1, 64'(ndrop[1] - d), 64'd1);
    chk("drp_peak", 1, 64'(peak[1]), 64'd2);
    chk("drp_out", 1, 64'(outb[1] - b), 64'd5);
`else
    // oversize packet streams through via the full fallback without stalling
    m_tready[1] = 1; b = outb[1]; tot = 0;
    for (int k = 0; k < 20; k++) begin
      send(1, mk(32'h4000_0000 + k, 4'(k), k == 19, 1'(k)), c);
      tot += c;
    end
    chk("fb_cycles", 1, 64'(tot), 64'd20);
    repeat (25) step();
    chk("fb_out", 1, 64'(outb[1] - b), 64'd20);
`endif

    // registered output: two cycles from write to valid
    m_tready[2] = 1;
    send(2, mk(32'hA5A5_0001, 4'h3, 1, 1), c);
    chk("or_lat1", 2, 64'(m_tvalid[2]), 64'd0);
    chk("or_cnt1", 2, 64'(fifo_cnt[2]), 64'd1);
    step();
    chk("or_lat2", 2, 64'(m_tvalid[2]), 64'd1);
    chk("or_data", 2, 64'(m_tdata[2]), 64'hA5A5_0001);
    chk("or_cnt2", 2, 64'(fifo_cnt[2]), 64'd0);
    repeat (3) step();

    // random traffic on all three; holds beats until accepted
    b2 = outb[2]; n = 0;
    while ((outb[2] - b2) < 10000 && n < 60000) begin
      if (n % 1000 == 0)
        for (int i = 0; i < 3; i++) begin
          pv[i] = $urandom_range(100, 30);
          pr[i] = $urandom_range(100, 20);
        end
      for (int i = 0; i < 3; i++) begin
        if (!s_tvalid[i] || acc[i]) begin
          if ($urandom_range(99, 0) < pv[i]) begin
            if (rem[i] == 0)
              rem[i] = (i == 1 && $urandom_range(9, 0) == 0) ? 18 : $urandom_range(8, 1);
            drive(i, mk($urandom, 4'($urandom), rem[i] == 1, 1'($urandom)));
            rem[i]--;
          end else begin
            s_tvalid[i] = 0;
          end
        end
        m_tready[i] = ($urandom_range(99, 0) < pr[i]);
      end
      step();
      n++;
    end
    chk("or_beats", 2, 64'((outb[2] - b2) >= 10000), 64'd1);

    for (int i = 0; i < 3; i++) begin s_tvalid[i] = 0; m_tready[i] = 1; end
    repeat (40) step();
    chk("end_cnt", 0, 64'(fifo_cnt[0]), 64'd0);
    chk("end_cnt", 2, 64'(fifo_cnt[2]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
